// File: rtl/alu_flag_stage.sv
// rtl/alu_flag_stage.sv - ALU result FIFO stage with condition-flag commit on consume
//
// Buffers ALU results in a small in-order FIFO so a stalling consumer does not
// back-pressure the combinational ALU. Condition flags are committed from each
// entry as it leaves the FIFO.
//
// Optional feature macro: ALU_ERR_CNT_EN (adds the saturating err_cnt output).
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  producer handshake (in_ready low when full or in reset)
//   ALU_Out, Error,      ALU result, signed-overflow indication, opcode
//   Opcode               (0 add, 1 sub, 2 nand, 3 xor)
//   out_valid/out_ready  consumer handshake for the head entry
//   Result, Opcode_Out,  head entry fields; Err_Out is forced 0 for logic ops
//   Err_Out
//   Flag_Z/N/V           flags committed from the most recently consumed entry
//   err_cnt              (ALU_ERR_CNT_EN only) saturating count of consumed errors
module alu_flag_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic             Error,
    input  logic [1:0]       Opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [1:0]       Opcode_Out,
    output logic             Err_Out,
    output logic             Flag_Z,
    output logic             Flag_N,
    output logic             Flag_V
`ifdef ALU_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
        $error("alu_flag_stage: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] res;
        logic             err;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    entry_t        head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // in_ready depends only on registered state and rst, never on out_ready,
    // so a full FIFO turns away a push even while it is being drained.
    assign in_ready  = ~full & ~rst;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign Result     = head.res;
    assign Opcode_Out = head.op;
    assign Err_Out    = head.err;

    // Storage is cleared on reset so the head fields read zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                // Overflow is meaningless for the logic ops, so it is dropped at capture.
                mem[wr_ptr[AW-1:0]] <= '{op: Opcode, res: ALU_Out, err: Error & ~Opcode[1]};
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Flags are taken from the entry leaving the FIFO; N and V only follow
    // arithmetic ops and keep their earlier values across logic ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Flag_Z <= 1'b0;
            Flag_N <= 1'b0;
            Flag_V <= 1'b0;
        end else if (pop) begin
            Flag_Z <= (head.res == '0);
            if (!head.op[1]) begin
                Flag_N <= head.res[WIDTH-1];
                Flag_V <= head.err;
            end
        end
    end

`ifdef ALU_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (pop && head.err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
